// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc_pkg
// Description : Shared types and default constants for the traffic light
//               controller and its pedestrian front end.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        SERVING  = 2'd2,
        COOLDOWN = 2'd3
    } ped_state_t;

    localparam int c_SYNC_STAGES_DEF     = 2;
    localparam int c_DEBOUNCE_CYCLES_DEF = 4;
    localparam int c_WAIT_TIMEOUT_DEF    = 64;
    localparam int c_COOLDOWN_CYCLES_DEF = 16;

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Synchronises a raw push-button, debounces it and emits a
//               one-cycle pulse on each clean rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_button_raw,
    output logic deb_level,
    output logic press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_deb_level;
    logic                   r_deb_level_d;
    logic                   w_sample;

    assign w_sample = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync        <= '0;
            r_cnt         <= '0;
            r_deb_level   <= 1'b0;
            r_deb_level_d <= 1'b0;
        end else begin
            r_sync        <= {r_sync[SYNC_STAGES-2:0], i_button_raw};
            r_deb_level_d <= r_deb_level;
            // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
            if (w_sample == r_deb_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_deb_level <= ~r_deb_level;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign deb_level = r_deb_level;
    assign press     = r_deb_level & ~r_deb_level_d;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : ped_request_conditioner
// Description : Turns debounced crosswalk presses into a held request with
//               grant handshake, cooldown, one-deep memo and wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ped_request_conditioner
    import tlc_pkg::*;
#(
    parameter int SYNC_STAGES     = c_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int WAIT_TIMEOUT    = c_WAIT_TIMEOUT_DEF,
    parameter int COOLDOWN_CYCLES = c_COOLDOWN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Button_raw,
    input  logic       Pedestrian_allow,
    output logic       Pedestrian_req,
    output logic       Wait_lamp,
    output logic       Req_timeout,
    output logic [7:0] Served_count
);

    localparam int c_WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam int c_CD_W   = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_TIMEOUT - 1);
    localparam logic [c_CD_W-1:0]   c_CD_LAST   = c_CD_W'(COOLDOWN_CYCLES - 1);

    ped_state_t          r_state;
    ped_state_t          w_next_state;
    logic                r_memo;
    logic                w_memo_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_CD_W-1:0]   r_cd_cnt;
    logic                r_req;
    logic                r_lamp;
    logic                r_timeout;
    logic [7:0]          r_served;
    logic                w_press;
    logic                w_unused_deb_level;

    button_debouncer #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .rst_n        (reset),
        .i_button_raw (Button_raw),
        .deb_level    (w_unused_deb_level),
        .press        (w_press)
    );

    always_comb begin
        w_next_state = r_state;
        w_memo_next  = r_memo;
        case (r_state)
            IDLE: begin
                if (w_press) w_next_state = PENDING;
            end
            PENDING: begin
                if (Pedestrian_allow) w_next_state = SERVING;
            end
            SERVING: begin
                if (!Pedestrian_allow) w_next_state = COOLDOWN;
                if (w_press) w_memo_next = 1'b1;
            end
            COOLDOWN: begin
                // A press landing on the last cooldown cycle is served directly
                if (r_cd_cnt == c_CD_LAST) begin
                    if (r_memo || w_press) begin
                        w_next_state = PENDING;
                        w_memo_next  = 1'b0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_press) begin
                    w_memo_next = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_memo     <= 1'b0;
            r_wait_cnt <= '0;
            r_cd_cnt   <= '0;
            r_req      <= 1'b0;
            r_lamp     <= 1'b0;
            r_timeout  <= 1'b0;
            r_served   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_memo    <= w_memo_next;
            r_req     <= (w_next_state == PENDING);
            r_lamp    <= (w_next_state == PENDING) | w_memo_next;
            r_timeout <= 1'b0;

            if (r_state == PENDING && w_next_state == PENDING) begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    r_timeout  <= 1'b1;
                    r_wait_cnt <= '0;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end

            if (r_state == COOLDOWN && w_next_state == COOLDOWN) begin
                r_cd_cnt <= r_cd_cnt + 1'b1;
            end else begin
                r_cd_cnt <= '0;
            end

            if (r_state == SERVING && w_next_state == COOLDOWN && r_served != 8'hFF) begin
                r_served <= r_served + 8'd1;
            end
        end
    end

    assign Pedestrian_req = r_req;
    assign Wait_lamp      = r_lamp;
    assign Req_timeout    = r_timeout;
    assign Served_count   = r_served;

endmodule : ped_request_conditioner
`default_nettype wire

// File: tb/tb_ped_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_request_conditioner
// Description : Scoreboard-driven bench for the pedestrian request front end.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_request_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Button_raw = 1'b0;
    logic       Pedestrian_allow = 1'b0;
    logic       Pedestrian_req;
    logic       Wait_lamp;
    logic       Req_timeout;
    logic [7:0] Served_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       req;
        logic       lamp;
        logic       tmo;
        logic [7:0] served;
    } exp_t;

    exp_t sb[$];

    ped_request_conditioner dut (
        .clk              (clk),
        .reset            (reset),
        .Button_raw       (Button_raw),
        .Pedestrian_allow (Pedestrian_allow),
        .Pedestrian_req   (Pedestrian_req),
        .Wait_lamp        (Wait_lamp),
        .Req_timeout      (Req_timeout),
        .Served_count     (Served_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void push_exp(input int c, input logic rq, input logic lp,
                                     input logic tm, input logic [7:0] sv);
        exp_t e;
        e.cyc = c; e.req = rq; e.lamp = lp; e.tmo = tm; e.served = sv;
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        Button_raw = 1'b0;
        Pedestrian_allow = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        sb.delete();
    endtask

    task automatic test_reset();
        Button_raw = 1'b1;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== 11'd0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got req=%b lamp=%b tmo=%b served=%0d exp all 0",
                         cyc, Pedestrian_req, Wait_lamp, Req_timeout, Served_count);
            end
        end
        Button_raw = 1'b0;
    endtask

    task automatic test_press_latency();
        int c0;
        exp_t e;
        do_reset();
        c0 = cyc;
        Button_raw = 1'b1;
        for (int k = 1; k <= 6; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        push_exp(c0 + 7, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL press_latency k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - c0, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int c0;
        exp_t e;
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        c0 = cyc;
        Button_raw = pat[0];
        for (int k = 1; k <= 15; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL bounce k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - c0, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
            Button_raw = (i < 5) ? pat[i] : 1'b0;
        end
    endtask

    task automatic test_grant_release();
        int c0, r, m;
        exp_t e;
        do_reset();
        c0 = cyc;
        r = c0 + 7;
        m = r + 8;
        Button_raw = 1'b1;
        for (int k = 1; k <= 6; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = r; c <= r + 2; c++) push_exp(c, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int c = r + 3; c < m; c++) push_exp(c, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = m; c <= m + 20; c++) push_exp(c, 1'b0, 1'b0, 1'b0, 8'd1);
        while (cyc < m + 20) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL grant_release k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - c0, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
            if (cyc == r)     Button_raw = 1'b0;
            if (cyc == r + 2) Pedestrian_allow = 1'b1;
            if (cyc == r + 7) Pedestrian_allow = 1'b0;
        end
    endtask

    task automatic test_memo_back_to_back();
        int c0, r, m;
        exp_t e;
        do_reset();
        c0 = cyc;
        r = c0 + 7;
        m = r + 33;
        Button_raw = 1'b1;
        for (int k = 1; k <= 6; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        push_exp(r, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int c = r + 1; c <= r + 14; c++) push_exp(c, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = r + 15; c < m; c++) push_exp(c, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int c = m; c <= m + 15; c++) push_exp(c, 1'b0, 1'b1, 1'b0, 8'd1);
        push_exp(m + 16, 1'b1, 1'b1, 1'b0, 8'd1);
        push_exp(m + 17, 1'b0, 1'b0, 1'b0, 8'd1);
        push_exp(m + 18, 1'b0, 1'b0, 1'b0, 8'd1);
        for (int c = m + 19; c <= m + 40; c++) push_exp(c, 1'b0, 1'b0, 1'b0, 8'd2);
        while (cyc < m + 40) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL memo k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - c0, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
            if (cyc == r) begin
                Button_raw = 1'b0;
                Pedestrian_allow = 1'b1;
            end
            if (cyc == r + 8)  Button_raw = 1'b1;
            if (cyc == r + 16) Button_raw = 1'b0;
            if (cyc == r + 24) Button_raw = 1'b1;
            if (cyc == r + 32) Pedestrian_allow = 1'b0;
            if (cyc == m + 16) Pedestrian_allow = 1'b1;
            if (cyc == m + 18) Pedestrian_allow = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int c0, r;
        exp_t e;
        do_reset();
        c0 = cyc;
        r = c0 + 7;
        Button_raw = 1'b1;
        for (int k = 1; k <= 6; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k <= 130; k++)
            push_exp(r + k, 1'b1, 1'b1, (k == 64 || k == 128), 8'd0);
        while (cyc < r + 130) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL timeout k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - r, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        exp_t e;
        do_reset();
        Button_raw = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        Button_raw = 1'b0;
        checks++;
        if (Pedestrian_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre got req=%b exp req=1", Pedestrian_req);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_mid_async got req=%b lamp=%b tmo=%b served=%0d exp all 0",
                     Pedestrian_req, Wait_lamp, Req_timeout, Served_count);
        end
        tick();
        tick();
        reset = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 20; k++) push_exp(c0 + k, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if ({Pedestrian_req, Wait_lamp, Req_timeout, Served_count} !== {e.req, e.lamp, e.tmo, e.served}) begin
                    failures++;
                    $display("FAIL reset_mid_after k=%0d got req=%b lamp=%b tmo=%b served=%0d exp req=%b lamp=%b tmo=%b served=%0d",
                             cyc - c0, Pedestrian_req, Wait_lamp, Req_timeout, Served_count, e.req, e.lamp, e.tmo, e.served);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_bounce();
        test_grant_release();
        test_memo_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d simulation did not complete", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ped_request_conditioner
`default_nettype wire

// File: doc/ped_request_conditioner.md
# ped_request_conditioner

Upstream front end for the traffic light controller's pedestrian input. It synchronises and debounces the raw crosswalk push-button and turns each clean press into a level request, `Pedestrian_req`, which it holds until the controller answers with `Pedestrian_allow`. It enforces a cooldown after each crossing, remembers one press made during service or cooldown, drives the "WAIT" lamp, and flags requests left unserved too long.

## Interface
- `SYNC_STAGES`, 2: flops in the button synchroniser (≥2).
- `DEBOUNCE_CYCLES`, 4: number of consecutive differing synchronised samples required before the debounced level toggles (≥1).
- `WAIT_TIMEOUT`, 64: cycles in PENDING without a grant before `Req_timeout` pulses.
- `COOLDOWN_CYCLES`, 16: cycles after grant release during which no new request is issued (≥1).
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Button_raw`  in  1  raw, asynchronous, bouncing push-button (1 = pressed).
- `Pedestrian_allow`  in  1  grant from the traffic light controller.
- `Pedestrian_req`  out  1  registered request level to the controller.
- `Wait_lamp`  out  1  registered; lit while a crossing is requested or remembered.
- `Req_timeout`  out  1  registered one-cycle pulse.
- `Served_count`  out  8  registered count of completed grants, saturating at 255.

## Operation
- Reset (`reset`=0): all outputs 0, FSM IDLE, synchroniser flops 0, debounced level 0, every counter 0, memo flag 0.
- Debounce: `cnt` increments each cycle the synchronised sample differs from `deb_level`. It clears when they match. When `cnt`=DEBOUNCE_CYCLES-1 and they still differ, `deb_level` toggles and `cnt` clears. `press` = `deb_level` & ~`deb_level_d`, one cycle wide. Only rising edges matter.
- FSM states: IDLE, PENDING, SERVING, COOLDOWN.
  - IDLE: on `press` go to PENDING. `Pedestrian_allow` in IDLE is ignored.
  - PENDING: `Pedestrian_req`=1. `wait_cnt` increments each cycle. When it reaches WAIT_TIMEOUT-1, `Req_timeout` pulses and `wait_cnt` clears. The FSM stays in PENDING and repeats the pulse every WAIT_TIMEOUT cycles. `Pedestrian_allow`=1 moves to SERVING. `press` is ignored.
  - SERVING: `Pedestrian_req`=0. On `Pedestrian_allow` falling (sampled 0), go to COOLDOWN, load `cd_cnt`, and increment `Served_count` (saturating).
  - COOLDOWN: `cd_cnt` counts to COOLDOWN_CYCLES-1. At that point go to PENDING if `memo`=1 (then clear `memo`), otherwise go to IDLE.
- `memo`: set by `press` in SERVING or COOLDOWN. It holds one entry; further presses are absorbed.
- `Wait_lamp` = (next state is PENDING) | `memo`, registered.
- Simultaneous events:
  - `press` and `Pedestrian_allow` in the same cycle in PENDING: grant wins.
  - `press` on the final COOLDOWN cycle: the FSM goes to PENDING.
- Reset mid-operation returns everything to reset values immediately. A button still held after reset release produces a fresh press after the normal latency.

## Timing
- Press latency: `Button_raw` goes 1 and stays stable. `Pedestrian_req` is first high after rising edge SYNC_STAGES+DEBOUNCE_CYCLES+1, counted from the first edge that samples 1. Defaults give 7 edges.
- Grant response: `Pedestrian_allow` is sampled 1 at edge n. `Pedestrian_req`=0 after edge n.
- Release: `Pedestrian_allow` is sampled 0 at edge m. `Served_count` updates after edge m. The earliest next `Pedestrian_req` is after edge m+COOLDOWN_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no press.
- All outputs are driven straight from flops. There is no combinational path from input to output.

## Structure
- Package `tlc_pkg`: `ped_state_t` enum (IDLE, PENDING, SERVING, COOLDOWN) and default parameter constants. The controller also uses this package.
- Sub-module `button_debouncer` (params SYNC_STAGES, DEBOUNCE_CYCLES; outputs `deb_level`, `press`). The FSM, counters, memo and outputs live in the top.

## Test plan
- Reset, then hold `Button_raw`=1: `Pedestrian_req` rises after exactly 7 edges. `Wait_lamp`=1 at the same time.
- Bounce pattern 1,0,1,1,0 (one cycle each), then 0: no `Pedestrian_req`, `Wait_lamp` stays 0.
- Press, then grant 3 cycles after the request and drop it 5 cycles later:
  - `Pedestrian_req` falls the cycle after the grant.
  - `Served_count`=1.
  - No new request for 16 cycles.
- Two presses during SERVING:
  - `memo` set, `Wait_lamp`=1.
  - Exactly one new request on the cycle after cooldown ends.
  - `Served_count` increments once per grant.
- Leave the request ungranted for 130 cycles: `Req_timeout` pulses at cycles 64 and 128 of PENDING. `Pedestrian_req` stays 1.
- Assert `reset`=0 in PENDING: all outputs 0 immediately. With the button released, there is no request after reset is deasserted.
